fetch_queue: RTL and testbench

Decoupling instruction queue between the fetch stage and decode. It captures each returned instruction together with its fetch PC and branch-prediction tag, and presents them in order to decode through a valid/ready handshake. A misprediction flushes everything in flight. It absorbs decode stalls so fetch keeps requesting until the queue fills; `in_ready` low is fetch's back-pressure.

---
 rtl/fetch_queue_if.sv | 25 ++
 rtl/fetch_queue.sv | 49 ++++
 tb/tb_fetch_queue.sv | 115 +++++++++++
 3 files changed

// File: rtl/fetch_queue_if.sv
// fetch_queue_if: fetch-side push, decode-side pop and flush signals of the instruction queue
interface fetch_queue_if #(parameter int DEPTH = 4);
  logic                     flush;
  logic                     in_valid;
  logic [31:0]              in_instr;
  logic [31:0]              in_pc;
  logic                     in_pred_taken;
  logic [31:0]              in_pred_target;
  logic                     in_ready;
  logic                     out_valid;
  logic                     out_ready;
  logic [31:0]              out_instr;
  logic [31:0]              out_pc;
  logic                     out_pred_taken;
  logic [31:0]              out_pred_target;
  logic [$clog2(DEPTH):0]   count;
  modport master (
    output flush, in_valid, in_instr, in_pc, in_pred_taken, in_pred_target, out_ready,
    input  in_ready, out_valid, out_instr, out_pc, out_pred_taken, out_pred_target, count
  );
  modport slave (
    input  flush, in_valid, in_instr, in_pc, in_pred_taken, in_pred_target, out_ready,
    output in_ready, out_valid, out_instr, out_pc, out_pred_taken, out_pred_target, count
  );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: in-order instruction queue between fetch and decode with mispredict flush
module fetch_queue #(
  parameter int DEPTH = 4
) (
  input logic           clk,
  input logic           rst,
  fetch_queue_if.slave  q
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        pred_taken;
    logic [31:0] pred_target;
  } entry_t;
  entry_t          mem [DEPTH];
  entry_t          head;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     cnt;
  logic            push;
  logic            pop;
  assign q.in_ready  = cnt != FULL;
  assign q.out_valid = cnt != '0;
  assign q.count     = cnt;
  assign push = q.in_valid && q.in_ready && !q.flush;
  assign pop  = q.out_valid && q.out_ready && !q.flush;
  assign head = mem[rd_ptr];
  // An empty queue presents a NOP so decode never sees stale storage.
  assign q.out_instr       = q.out_valid ? head.instr : 32'h0000_0013;
  assign q.out_pc          = q.out_valid ? head.pc : 32'h0;
  assign q.out_pred_taken  = q.out_valid && head.pred_taken;
  assign q.out_pred_target = q.out_valid ? head.pred_target : 32'h0;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst || q.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {q.in_instr, q.in_pc, q.in_pred_taken, q.in_pred_target};
  end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: random and directed stimulus against a queue-based reference model
module tb_fetch_queue;
  localparam int DEPTH = 4;
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        pt;
    logic [31:0] tgt;
  } ent_t;
  logic clk = 0;
  logic rst = 0;
  int checks = 0;
  int failures = 0;
  ent_t exp_q[$];
  fetch_queue_if #(.DEPTH(DEPTH)) bus ();
  fetch_queue #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .q(bus));
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", n, a, e);
    end
  endtask
  // Monitor: compare against the model mid-cycle, then advance the model for the coming edge.
  always @(negedge clk) begin
    if (!rst) begin
      exp_q.delete();
      chk("rst_out_valid", {31'b0, bus.out_valid}, 0);
      chk("rst_count", {29'b0, bus.count}, 0);
    end else begin
      chk("count", {29'b0, bus.count}, exp_q.size());
      chk("in_ready", {31'b0, bus.in_ready}, {31'b0, exp_q.size() != DEPTH});
      chk("out_valid", {31'b0, bus.out_valid}, {31'b0, exp_q.size() != 0});
      chk("out_instr", bus.out_instr, exp_q.size() != 0 ? exp_q[0].instr : 32'h13);
      chk("out_pc", bus.out_pc, exp_q.size() != 0 ? exp_q[0].pc : 32'h0);
      chk("out_pred_taken", {31'b0, bus.out_pred_taken}, {31'b0, exp_q.size() != 0 && exp_q[0].pt});
      chk("out_pred_target", bus.out_pred_target, exp_q.size() != 0 ? exp_q[0].tgt : 32'h0);
      if (bus.flush) exp_q.delete();
      else begin
        automatic bit do_push = bus.in_valid && exp_q.size() != DEPTH;
        if (bus.out_ready && exp_q.size() != 0) void'(exp_q.pop_front());
        if (do_push) exp_q.push_back({bus.in_instr, bus.in_pc, bus.in_pred_taken, bus.in_pred_target});
      end
    end
  end
  task automatic step(input logic iv, input logic [31:0] instr, input logic [31:0] pc,
                      input logic pt, input logic [31:0] tgt, input logic ordy, input logic fl);
    bus.in_valid = iv;
    bus.in_instr = instr;
    bus.in_pc = pc;
    bus.in_pred_taken = pt;
    bus.in_pred_target = tgt;
    bus.out_ready = ordy;
    bus.flush = fl;
    @(posedge clk);
    #1;
  endtask
  task automatic push(input logic [31:0] pc, input logic ordy);
    step(1, pc ^ 32'hA5A5_0000, pc, pc[2], pc + 32'h40, ordy, 0);
  endtask
  task automatic idle(input logic ordy);
    step(0, 32'hDEAD_BEEF, 32'hFFFF_FFFC, 1, 32'h1234_5678, ordy, 0);
  endtask
  initial begin
    idle(0);
    idle(0);
    chk("reset_instr", bus.out_instr, 32'h13);
    chk("reset_in_ready", {31'b0, bus.in_ready}, 1);
    rst = 1;
    idle(1);
    step(1, 32'h00A0_0093, 32'h100, 0, 32'h0, 1, 0);
    chk("lat1_instr", bus.out_instr, 32'h00A0_0093);
    chk("lat1_pc", bus.out_pc, 32'h100);
    idle(1);
    chk("drain_valid", {31'b0, bus.out_valid}, 0);
    chk("drain_instr", bus.out_instr, 32'h13);
    for (int i = 0; i < 5; i++) push(32'(i * 4), 0);
    chk("full_count", {29'b0, bus.count}, 4);
    chk("full_in_ready", {31'b0, bus.in_ready}, 0);
    for (int i = 0; i < 4; i++) idle(1);
    for (int i = 0; i < 10; i++) push(32'h1000 + 32'(i * 4), 1);
    idle(1);
    idle(1);
    for (int i = 0; i < 3; i++) push(32'h2000 + 32'(i * 4), 0);
    push(32'h200C, 1);
    chk("pushpop_count", {29'b0, bus.count}, 3);
    chk("pushpop_head", bus.out_pc, 32'h2004);
    step(1, 32'h1111_1111, 32'h2100, 1, 32'h0, 1, 1);
    chk("flush_count", {29'b0, bus.count}, 0);
    chk("flush_in_ready", {31'b0, bus.in_ready}, 1);
    step(1, 32'h2222_2222, 32'h200, 1, 32'h300, 0, 0);
    chk("post_flush_pc", bus.out_pc, 32'h200);
    chk("post_flush_pt", {31'b0, bus.out_pred_taken}, 1);
    chk("post_flush_tgt", bus.out_pred_target, 32'h300);
    idle(1);
    push(32'h3000, 0);
    push(32'h3004, 0);
    #2 rst = 0;
    #1;
    chk("async_valid", {31'b0, bus.out_valid}, 0);
    chk("async_count", {29'b0, bus.count}, 0);
    @(posedge clk);
    #1 rst = 1;
    push(32'h4000, 1);
    idle(1);
    for (int i = 0; i < 600; i++) begin
      automatic logic [31:0] r = $urandom;
      step(r[0] | r[1], $urandom, $urandom, r[2], $urandom, r[3] & ~r[4] | r[5], $urandom_range(0, 24) == 0);
    end
    idle(1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
